// File: rtl/dispensador_troco.sv
// ---------------------------------------------------------------------------
// dispensador_troco
//   Pay-out side of the vending machine. Takes the credited balance (units of
//   R$0.25) and either sells (pulses produto, returns balance-PRECO) or
//   cancels (returns the whole balance). Change is paid one coin at a time
//   through the ejector handshake, greedy by value, against internal stock
//   counters. On a coin shortage the FSM parks in FALTA until reabastecer.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   saldo_in     in   [3:0] credited balance, sampled with iniciar/cancelar
//   iniciar      in   sell request (OCIOSO only)
//   cancelar     in   refund request (OCIOSO only, wins over iniciar)
//   reabastecer  in   reload stocks (OCIOSO and FALTA only)
//   ejetor_ok    in   ejector accepted the coin on moeda_out this cycle
//   ejetar       out  coin request valid
//   moeda_out    out  [1:0] 1=25c 2=50c 3=R$1, 0 when idle
//   produto      out  1-cycle pulse, release product
//   concluido    out  1-cycle pulse, transaction finished
//   falta_troco  out  high while parked in FALTA
//   restante     out  [3:0] change still owed
//   ocupado      out  high in every state except OCIOSO
//   estado       out  [2:0] OCIOSO=0 SELECIONA=1 EJETA=2 FIM=3 FALTA=4
// ---------------------------------------------------------------------------
module dispensador_troco #(
    parameter int unsigned PRECO       = 6,
    parameter int unsigned EST_INI_25  = 8,
    parameter int unsigned EST_INI_50  = 8,
    parameter int unsigned EST_INI_100 = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] saldo_in,
    input  logic       iniciar,
    input  logic       cancelar,
    input  logic       reabastecer,
    input  logic       ejetor_ok,
    output logic       ejetar,
    output logic [1:0] moeda_out,
    output logic       produto,
    output logic       concluido,
    output logic       falta_troco,
    output logic [3:0] restante,
    output logic       ocupado,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        SELECIONA = 3'd1,
        EJETA     = 3'd2,
        FIM       = 3'd3,
        FALTA     = 3'd4
    } estado_t;

    localparam logic [3:0] PRECO_W = 4'(PRECO);
    localparam logic [3:0] INI_25  = 4'(EST_INI_25);
    localparam logic [3:0] INI_50  = 4'(EST_INI_50);
    localparam logic [3:0] INI_100 = 4'(EST_INI_100);

    estado_t    estado_q;
    logic [3:0] restante_q;
    logic       ejetar_q;
    logic [1:0] moeda_q;
    logic       produto_q;
    logic       concluido_q;
    logic [3:0] est25_q, est50_q, est100_q;

    // Greedy choice for the amount still owed; 0 means no coin can be paid.
    // The 25c branch needs no amount test: it is only used when restante != 0.
    logic [1:0] moeda_d;
    always_comb begin
        moeda_d = 2'd0;
        if (restante_q >= 4'd4 && est100_q != 4'd0)
            moeda_d = 2'd3;
        else if (restante_q >= 4'd2 && est50_q != 4'd0)
            moeda_d = 2'd2;
        else if (est25_q != 4'd0)
            moeda_d = 2'd1;
    end

    // Value in 0.25 units of the coin currently being ejected.
    logic [3:0] valor_q;
    always_comb begin
        case (moeda_q)
            2'd1:    valor_q = 4'd1;
            2'd2:    valor_q = 4'd2;
            2'd3:    valor_q = 4'd4;
            default: valor_q = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q    <= OCIOSO;
            restante_q  <= 4'd0;
            ejetar_q    <= 1'b0;
            moeda_q     <= 2'd0;
            produto_q   <= 1'b0;
            concluido_q <= 1'b0;
            est25_q     <= INI_25;
            est50_q     <= INI_50;
            est100_q    <= INI_100;
        end else begin
            produto_q   <= 1'b0;
            concluido_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (cancelar) begin
                        restante_q <= saldo_in;
                        estado_q   <= SELECIONA;
                    end else if (iniciar && saldo_in >= PRECO_W) begin
                        restante_q <= saldo_in - PRECO_W;
                        produto_q  <= 1'b1;
                        estado_q   <= SELECIONA;
                    end else if (reabastecer) begin
                        est25_q  <= INI_25;
                        est50_q  <= INI_50;
                        est100_q <= INI_100;
                    end
                end
                SELECIONA: begin
                    if (restante_q == 4'd0) begin
                        concluido_q <= 1'b1;
                        estado_q    <= FIM;
                    end else if (moeda_d != 2'd0) begin
                        moeda_q  <= moeda_d;
                        ejetar_q <= 1'b1;
                        estado_q <= EJETA;
                    end else begin
                        estado_q <= FALTA;
                    end
                end
                EJETA: begin
                    // Request is held untouched until the ejector acks.
                    if (ejetor_ok) begin
                        ejetar_q   <= 1'b0;
                        moeda_q    <= 2'd0;
                        restante_q <= restante_q - valor_q;
                        case (moeda_q)
                            2'd1:    est25_q  <= est25_q - 4'd1;
                            2'd2:    est50_q  <= est50_q - 4'd1;
                            2'd3:    est100_q <= est100_q - 4'd1;
                            default: ;
                        endcase
                        estado_q <= SELECIONA;
                    end
                end
                FIM: begin
                    restante_q <= 4'd0;
                    estado_q   <= OCIOSO;
                end
                FALTA: begin
                    if (reabastecer) begin
                        est25_q  <= INI_25;
                        est50_q  <= INI_50;
                        est100_q <= INI_100;
                        estado_q <= SELECIONA;
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign ejetar      = ejetar_q;
    assign moeda_out   = moeda_q;
    assign produto     = produto_q;
    assign concluido   = concluido_q;
    assign restante    = restante_q;
    assign estado      = estado_q;
    assign ocupado     = (estado_q != OCIOSO);
    assign falta_troco = (estado_q == FALTA);

endmodule

// File: tb/tb_dispensador_troco.sv
// ---------------------------------------------------------------------------
// tb_dispensador_troco
//   Two instances: unit 0 with default stocks, unit 1 with a single 25c coin
//   and nothing else, so shortage / refill paths are reachable. A behavioural
//   model per unit predicts every output each cycle; directed sequences add
//   hand-computed expectations on coin order, remaining change and pulses.
// ---------------------------------------------------------------------------
module tb_dispensador_troco;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] saldo [2];
    logic [1:0] ini, can, reab, ok;

    logic       ejetar_o [2];
    logic [1:0] moeda_o  [2];
    logic       prod_o   [2];
    logic       conc_o   [2];
    logic       falta_o  [2];
    logic [3:0] rest_o   [2];
    logic       ocup_o   [2];
    logic [2:0] est_o    [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dispensador_troco u_dut0 (
        .clk(clk), .reset(reset), .saldo_in(saldo[0]), .iniciar(ini[0]),
        .cancelar(can[0]), .reabastecer(reab[0]), .ejetor_ok(ok[0]),
        .ejetar(ejetar_o[0]), .moeda_out(moeda_o[0]), .produto(prod_o[0]),
        .concluido(conc_o[0]), .falta_troco(falta_o[0]), .restante(rest_o[0]),
        .ocupado(ocup_o[0]), .estado(est_o[0])
    );

    dispensador_troco #(.EST_INI_25(1), .EST_INI_50(0), .EST_INI_100(0)) u_dut1 (
        .clk(clk), .reset(reset), .saldo_in(saldo[1]), .iniciar(ini[1]),
        .cancelar(can[1]), .reabastecer(reab[1]), .ejetor_ok(ok[1]),
        .ejetar(ejetar_o[1]), .moeda_out(moeda_o[1]), .produto(prod_o[1]),
        .concluido(conc_o[1]), .falta_troco(falta_o[1]), .restante(rest_o[1]),
        .ocupado(ocup_o[1]), .estado(est_o[1])
    );

    // ---------------- behavioural model ----------------
    // st: 0 idle, 1 choosing, 2 ejecting, 3 done, 4 shortage
    typedef struct {
        int st;
        int rest;
        int coin;
        int s1, s2, s4;   // stock of 25c, 50c, R$1
        bit prod;
        bit conc;
    } m_t;

    m_t m [2];

    function automatic m_t m_init(int u);
        m_t n;
        n.st = 0; n.rest = 0; n.coin = 0; n.prod = 0; n.conc = 0;
        n.s1 = (u == 0) ? 8 : 1;
        n.s2 = (u == 0) ? 8 : 0;
        n.s4 = (u == 0) ? 8 : 0;
        return n;
    endfunction

    // Largest denomination not above the debt that is still in stock.
    function automatic int pick(int rest, int s4, int s2, int s1);
        int val [3];
        int stk [3];
        val = '{4, 2, 1};
        stk = '{s4, s2, s1};
        for (int k = 0; k < 3; k++)
            if (rest >= val[k] && stk[k] > 0) return 3 - k;
        return 0;
    endfunction

    function automatic m_t m_step(m_t c, int u, int s, bit i, bit cn, bit r, bit a);
        m_t n;
        m_t fresh;
        int v;
        n = c;
        n.prod = 0;
        n.conc = 0;
        fresh = m_init(u);
        case (c.st)
            0: begin
                if (cn) begin n.rest = s; n.st = 1; end
                else if (i && s >= 6) begin n.rest = s - 6; n.prod = 1; n.st = 1; end
                else if (r) begin n.s1 = fresh.s1; n.s2 = fresh.s2; n.s4 = fresh.s4; end
            end
            1: begin
                if (c.rest == 0) begin n.st = 3; n.conc = 1; end
                else begin
                    n.coin = pick(c.rest, c.s4, c.s2, c.s1);
                    n.st = (n.coin == 0) ? 4 : 2;
                end
            end
            2: if (a) begin
                v = (c.coin == 3) ? 4 : c.coin;
                n.rest = c.rest - v;
                if (c.coin == 1) n.s1--;
                if (c.coin == 2) n.s2--;
                if (c.coin == 3) n.s4--;
                n.coin = 0;
                n.st = 1;
            end
            3: begin n.rest = 0; n.st = 0; end
            4: if (r) begin n.s1 = fresh.s1; n.s2 = fresh.s2; n.s4 = fresh.s4; n.st = 1; end
            default: n.st = 0;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        for (int u = 0; u < 2; u++) begin
            if (!reset) m[u] <= m_init(u);
            else m[u] <= m_step(m[u], u, int'(saldo[u]), ini[u], can[u], reab[u], ok[u]);
        end
    end

    // Every cycle out of reset: all outputs of both units against the model.
    always @(negedge clk) begin
        if (reset) begin
            for (int u = 0; u < 2; u++) begin
                logic [13:0] act, exp;
                exp = {3'(m[u].st), m[u].st == 2, (m[u].st == 2) ? 2'(m[u].coin) : 2'd0,
                       m[u].prod, m[u].conc, m[u].st == 4, 4'(m[u].rest), m[u].st != 0};
                act = {est_o[u], ejetar_o[u], moeda_o[u], prod_o[u], conc_o[u],
                       falta_o[u], rest_o[u], ocup_o[u]};
                checks++;
                if (act !== exp) begin
                    failures++;
                    $display("FAIL model_u%0d t=%0t got=%h expected=%h", u, $time, act, exp);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int u, input int s, input bit i, input bit c);
        saldo[u] = 4'(s);
        ini[u] = i;
        can[u] = c;
        tick();
        ini[u] = 1'b0;
        can[u] = 1'b0;
    endtask

    // Services ejector requests with ack after d cycles until concluido or
    // FALTA. Coins and restante-at-request are packed one hex digit each.
    task automatic run_pay(input int u, input int d, input bit poke,
                           output int coins, output int rests,
                           output int nconc, output bit falta);
        int c;
        coins = 0; rests = 0; nconc = 0; falta = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (falta_o[u]) begin falta = 1; return; end
            if (conc_o[u]) begin
                nconc++;
                tick();
                if (conc_o[u]) nconc++;
                return;
            end
            if (ejetar_o[u]) begin
                c = int'(moeda_o[u]);
                coins = coins * 16 + c;
                rests = rests * 16 + int'(rest_o[u]);
                for (int k = 0; k < d; k++) begin
                    if (poke && k == 1) begin saldo[u] = 4'd15; ini[u] = 1'b1; end
                    tick();
                    ini[u] = 1'b0;
                    chk("hold_ejetar", int'(ejetar_o[u]), 1);
                    chk("hold_moeda", int'(moeda_o[u]), c);
                end
                ok[u] = 1'b1;
                tick();
                ok[u] = 1'b0;
            end else begin
                tick();
            end
        end
        chk("run_pay_timeout", 1, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int coins, rests, nconc;
        bit falta;
        saldo[0] = 4'd0; saldo[1] = 4'd0;
        ini = '0; can = '0; reab = '0; ok = '0;
        #2;
        for (int u = 0; u < 2; u++) begin
            chk("rst_outputs", int'({ejetar_o[u], moeda_o[u], prod_o[u], conc_o[u],
                                     falta_o[u], rest_o[u], ocup_o[u], est_o[u]}), 0);
        end
        tick(); tick();
        reset = 1'b1;
        tick();

        // 1: exact price, no change
        start(0, 6, 1, 0);
        chk("t1_produto", int'(prod_o[0]), 1);
        chk("t1_estado", int'(est_o[0]), 1);
        run_pay(0, 1, 0, coins, rests, nconc, falta);
        chk("t1_coins", coins, 0);
        chk("t1_concluido", nconc, 1);
        chk("t1_idle", int'(est_o[0]), 0);

        // 2: balance 13 -> change 7 = R$1 + 50c + 25c
        start(0, 13, 1, 0);
        chk("t2_produto", int'(prod_o[0]), 1);
        run_pay(0, 1, 0, coins, rests, nconc, falta);
        chk("t2_coins", coins, 'h321);
        chk("t2_rests", rests, 'h731);
        chk("t2_concluido", nconc, 1);
        chk("t2_restante", int'(rest_o[0]), 0);

        // 3: cancel beats sell, balance 5 refunded as R$1 + 25c
        start(0, 5, 1, 1);
        chk("t3_no_produto", int'(prod_o[0]), 0);
        chk("t3_restante", int'(rest_o[0]), 5);
        run_pay(0, 1, 0, coins, rests, nconc, falta);
        chk("t3_coins", coins, 'h31);
        chk("t3_rests", rests, 'h51);
        chk("t3_concluido", nconc, 1);

        // underpriced sell is ignored
        start(0, 5, 1, 0);
        chk("low_saldo_estado", int'(est_o[0]), 0);
        chk("low_saldo_produto", int'(prod_o[0]), 0);

        // 4: unit 1 runs out of 25c coins
        start(1, 9, 1, 0);
        chk("t4_produto", int'(prod_o[1]), 1);
        run_pay(1, 1, 0, coins, rests, nconc, falta);
        chk("t4_coins", coins, 'h1);
        chk("t4_falta", int'(falta), 1);
        chk("t4_falta_o", int'(falta_o[1]), 1);
        chk("t4_restante", int'(rest_o[1]), 2);
        tick();
        chk("t4_parked", int'(est_o[1]), 4);
        reab[1] = 1'b1;
        tick();
        reab[1] = 1'b0;
        chk("t4_reload_estado", int'(est_o[1]), 1);
        run_pay(1, 1, 0, coins, rests, nconc, falta);
        chk("t4b_coins", coins, 'h1);
        chk("t4b_falta", int'(falta), 1);
        chk("t4b_restante", int'(rest_o[1]), 1);

        // 5: slow ejector, iniciar poked while busy
        start(0, 10, 1, 0);
        run_pay(0, 5, 1, coins, rests, nconc, falta);
        chk("t5_coins", coins, 'h3);
        chk("t5_rests", rests, 'h4);
        chk("t5_concluido", nconc, 1);

        // 6: async reset while both units wait in EJETA
        saldo[0] = 4'd13; ini[0] = 1'b1; reab[1] = 1'b1;
        tick();
        ini[0] = 1'b0; reab[1] = 1'b0;
        tick();
        chk("t6_pre_ej0", int'(ejetar_o[0]), 1);
        chk("t6_pre_ej1", int'(ejetar_o[1]), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_ej0", int'(ejetar_o[0]), 0);
        chk("t6_ej1", int'(ejetar_o[1]), 0);
        chk("t6_est0", int'(est_o[0]), 0);
        chk("t6_est1", int'(est_o[1]), 0);
        chk("t6_moeda0", int'(moeda_o[0]), 0);
        tick();
        reset = 1'b1;
        tick();
        // unit 1 stock restored: one 25c coin available again
        start(1, 7, 1, 0);
        run_pay(1, 1, 0, coins, rests, nconc, falta);
        chk("t6_u1_coins", coins, 'h1);
        chk("t6_u1_concluido", nconc, 1);
        chk("t6_u1_nofalta", int'(falta), 0);
        // unit 0 full refund of 15
        start(0, 15, 0, 1);
        run_pay(0, 1, 0, coins, rests, nconc, falta);
        chk("t6_u0_coins", coins, 'h33321);
        chk("t6_u0_rests", rests, 'hFB731);
        chk("t6_u0_concluido", nconc, 1);

        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
